// File: rtl/air_hockey_pkg.sv
// Shared types, widths and saturating helpers for the air-hockey game logic.
package air_hockey_pkg;

    localparam int H_SIZE_DEF = 1024;
    localparam int V_SIZE_DEF = 768;
    localparam int POS_W      = 12;
    localparam int CAND_W     = 13;
    localparam int VEL_W      = 5;
    localparam int DIST_W     = 26;

    typedef enum logic [1:0] {
        ST_SERVE,
        ST_PLAY,
        ST_GOAL,
        ST_OVER
    } state_t;

    typedef logic signed [VEL_W-1:0]  vel_t;
    typedef logic signed [CAND_W-1:0] cand_t;

    function automatic vel_t clamp_vel(input cand_t v, input cand_t lim);
        cand_t r;
        if (v > lim)       r = lim;
        else if (v < -lim) r = -lim;
        else               r = v;
        return vel_t'(r);
    endfunction

    function automatic logic [POS_W-1:0] clamp_pos(input cand_t v, input cand_t lo, input cand_t hi);
        cand_t r;
        if (v < lo)      r = lo;
        else if (v > hi) r = hi;
        else             r = v;
        return r[POS_W-1:0];
    endfunction

    function automatic logic [3:0] score_inc(input logic [3:0] s, input logic [3:0] win);
        return (s >= win) ? win : s + 4'd1;
    endfunction

endpackage

// File: rtl/puck_mallet_hit.sv
// Two-stage puck/mallet proximity test: offsets first, then squared distance
// against the contact radius. Offsets travel alongside the flag.
module puck_mallet_hit
    import air_hockey_pkg::*;
#(
    parameter int HIT_R = 40
)(
    input  logic             clk,
    input  logic             rst,
    input  cand_t            px_i,
    input  cand_t            py_i,
    input  logic [POS_W-1:0] mx_i,
    input  logic [POS_W-1:0] my_i,
    output logic             hit_o,
    output cand_t            dx_o,
    output cand_t            dy_o
);

    localparam logic [DIST_W-1:0] HIT_R_SQ = DIST_W'(HIT_R * HIT_R);

    cand_t                    dx_q, dy_q;
    logic signed [DIST_W-1:0] dx_ext, dy_ext, dx_sq, dy_sq;
    logic [DIST_W-1:0]        dist_sq;

    assign dx_ext  = {{(DIST_W-CAND_W){dx_q[CAND_W-1]}}, dx_q};
    assign dy_ext  = {{(DIST_W-CAND_W){dy_q[CAND_W-1]}}, dy_q};
    assign dx_sq   = dx_ext * dx_ext;
    assign dy_sq   = dy_ext * dy_ext;
    // Both squares are below 2^25, so the sum cannot overflow 26 bits.
    assign dist_sq = $unsigned(dx_sq) + $unsigned(dy_sq);

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q  <= '0;
            dy_q  <= '0;
            hit_o <= 1'b0;
            dx_o  <= '0;
            dy_o  <= '0;
        end else begin
            dx_q  <= px_i - cand_t'({1'b0, mx_i});
            dy_q  <= py_i - cand_t'({1'b0, my_i});
            hit_o <= (dist_sq <= HIT_R_SQ);
            dx_o  <= dx_q;
            dy_o  <= dy_q;
        end
    end

endmodule

// File: rtl/puck_ctl.sv
// Per-frame puck physics: candidate move, wall/mallet detection, then a single
// commit three edges after the vblank rising edge.
module puck_ctl
    import air_hockey_pkg::*;
#(
    parameter int H_SIZE      = H_SIZE_DEF,
    parameter int V_SIZE      = V_SIZE_DEF,
    parameter int PUCK_R      = 16,
    parameter int MALLET_R    = 24,
    parameter int GOAL_TOP    = 284,
    parameter int GOAL_BOT    = 484,
    parameter int SPEED_MAX   = 8,
    parameter int SERVE_SPEED = 3,
    parameter int HOLD_FRAMES = 60,
    parameter int WIN_SCORE   = 7
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [11:0] mallet_l_xpos,
    input  logic [11:0] mallet_l_ypos,
    input  logic [11:0] mallet_r_xpos,
    input  logic [11:0] mallet_r_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        goal,
    output logic        game_over
);

    localparam cand_t       X_LO    = cand_t'(PUCK_R);
    localparam cand_t       X_HI    = cand_t'(H_SIZE - 1 - PUCK_R);
    localparam cand_t       Y_LO    = cand_t'(PUCK_R);
    localparam cand_t       Y_HI    = cand_t'(V_SIZE - 1 - PUCK_R);
    localparam cand_t       V_LIM   = cand_t'(SPEED_MAX);
    localparam vel_t        V_HIT   = vel_t'(SPEED_MAX);
    localparam vel_t        V_SERVE = vel_t'(SERVE_SPEED);
    localparam logic [11:0] X_MID   = 12'(H_SIZE / 2);
    localparam logic [11:0] Y_MID   = 12'(V_SIZE / 2);
    localparam logic [11:0] G_TOP   = 12'(GOAL_TOP);
    localparam logic [11:0] G_BOT   = 12'(GOAL_BOT);
    localparam logic [7:0]  HOLD    = 8'(HOLD_FRAMES);
    localparam logic [3:0]  WIN     = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        serve_neg_q, serve_neg_d;
    logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
    vel_t        vx_q, vx_d, vy_q, vy_d;
    logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
    logic        goal_q, goal_d;

    logic        vblnk_d_q, tick;
    logic        v1_q, v2_q, v3_q;
    cand_t       nx1_q, ny1_q, nx2_q, ny2_q, nx3_q, ny3_q;
    logic [3:0]  wall2_q, wall3_q;   // {x low, x high, y low, y high}

    logic [11:0] mal_x [2];
    logic [11:0] mal_y [2];
    logic        hit [2];
    cand_t       dx [2];
    cand_t       dy [2];

    assign tick     = vblnk_in & ~vblnk_d_q;
    assign mal_x[0] = mallet_l_xpos;
    assign mal_y[0] = mallet_l_ypos;
    assign mal_x[1] = mallet_r_xpos;
    assign mal_y[1] = mallet_r_ypos;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mallet
            puck_mallet_hit #(.HIT_R(PUCK_R + MALLET_R)) u_hit (
                .clk  (clk),
                .rst  (rst),
                .px_i (nx1_q),
                .py_i (ny1_q),
                .mx_i (mal_x[gi]),
                .my_i (mal_y[gi]),
                .hit_o(hit[gi]),
                .dx_o (dx[gi]),
                .dy_o (dy[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_d_q   <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            nx1_q       <= '0;
            ny1_q       <= '0;
            nx2_q       <= '0;
            ny2_q       <= '0;
            nx3_q       <= '0;
            ny3_q       <= '0;
            wall2_q     <= '0;
            wall3_q     <= '0;
            state_q     <= ST_SERVE;
            cnt_q       <= '0;
            serve_neg_q <= 1'b0;
            xpos_q      <= X_MID;
            ypos_q      <= Y_MID;
            vx_q        <= '0;
            vy_q        <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            goal_q      <= 1'b0;
        end else begin
            vblnk_d_q   <= vblnk_in;
            v1_q        <= tick;
            if (tick) begin
                nx1_q <= cand_t'({1'b0, xpos_q}) + cand_t'(vx_q);
                ny1_q <= cand_t'({1'b0, ypos_q}) + cand_t'(vy_q);
            end
            v2_q        <= v1_q;
            nx2_q       <= nx1_q;
            ny2_q       <= ny1_q;
            wall2_q     <= {nx1_q < X_LO, nx1_q > X_HI, ny1_q < Y_LO, ny1_q > Y_HI};
            v3_q        <= v2_q;
            nx3_q       <= nx2_q;
            ny3_q       <= ny2_q;
            wall3_q     <= wall2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            serve_neg_q <= serve_neg_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            goal_q      <= goal_d;
        end
    end

    logic  hit_any, side_goal;
    cand_t hit_dx, hit_dy;
    vel_t  vx_hit, vy_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        serve_neg_d = serve_neg_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        goal_d      = 1'b0;

        hit_any   = hit[0] | hit[1];
        hit_dx    = hit[0] ? dx[0] : dx[1];
        hit_dy    = hit[0] ? dy[0] : dy[1];
        vx_hit    = (hit_dx >= cand_t'(0)) ? V_HIT : -V_HIT;
        vy_hit    = clamp_vel(hit_dy >>> 2, V_LIM);
        side_goal = (wall3_q[3] | wall3_q[2]) && (ypos_q >= G_TOP) && (ypos_q <= G_BOT);

        case (state_q)
            ST_SERVE: begin
                xpos_d = X_MID;
                ypos_d = Y_MID;
                vx_d   = '0;
                vy_d   = '0;
                if (v3_q) begin
                    if (cnt_q == HOLD) begin
                        vx_d    = serve_neg_q ? -V_SERVE : V_SERVE;
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (v3_q) begin
                    if (hit_any) begin
                        vx_d   = vx_hit;
                        vy_d   = vy_hit;
                        xpos_d = clamp_pos(cand_t'({1'b0, xpos_q}) + cand_t'(vx_hit), X_LO, X_HI);
                        ypos_d = clamp_pos(cand_t'({1'b0, ypos_q}) + cand_t'(vy_hit), Y_LO, Y_HI);
                    end else if (side_goal) begin
                        goal_d = 1'b1;
                        vx_d   = '0;
                        vy_d   = '0;
                        cnt_d  = '0;
                        // The serve heads toward whoever just conceded.
                        if (wall3_q[3]) begin
                            score_r_d   = score_inc(score_r_q, WIN);
                            serve_neg_d = 1'b1;
                        end else begin
                            score_l_d   = score_inc(score_l_q, WIN);
                            serve_neg_d = 1'b0;
                        end
                        if (score_l_d == WIN || score_r_d == WIN) begin
                            state_d = ST_OVER;
                            xpos_d  = X_MID;
                            ypos_d  = Y_MID;
                        end else begin
                            state_d = ST_GOAL;
                        end
                    end else begin
                        xpos_d = clamp_pos(nx3_q, X_LO, X_HI);
                        ypos_d = clamp_pos(ny3_q, Y_LO, Y_HI);
                        if (wall3_q[3] | wall3_q[2]) vx_d = clamp_vel(-cand_t'(vx_q), V_LIM);
                        if (wall3_q[1] | wall3_q[0]) vy_d = clamp_vel(-cand_t'(vy_q), V_LIM);
                    end
                end
            end
            ST_GOAL: begin
                vx_d = '0;
                vy_d = '0;
                if (v3_q) begin
                    if (cnt_q == HOLD) begin
                        xpos_d  = X_MID;
                        ypos_d  = Y_MID;
                        cnt_d   = '0;
                        state_d = ST_SERVE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_OVER: begin
                xpos_d = X_MID;
                ypos_d = Y_MID;
                vx_d   = '0;
                vy_d   = '0;
            end
            default: state_d = ST_SERVE;
        endcase
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign goal      = goal_q;
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_puck_ctl.sv
// Directed game scenarios for puck_ctl with hand-traced puck trajectories.
module tb_puck_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk_in;
    logic [11:0] mallet_l_xpos, mallet_l_ypos, mallet_r_xpos, mallet_r_ypos;
    logic [11:0] xpos, ypos;
    logic [3:0]  score_l, score_r;
    logic        goal, game_over;

    int n_checks = 0;
    int n_errors = 0;
    int tick_n   = 0;
    int goal_hi  = 0;

    always #5 clk = ~clk;

    puck_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .vblnk_in     (vblnk_in),
        .mallet_l_xpos(mallet_l_xpos),
        .mallet_l_ypos(mallet_l_ypos),
        .mallet_r_xpos(mallet_r_xpos),
        .mallet_r_ypos(mallet_r_ypos),
        .xpos         (xpos),
        .ypos         (ypos),
        .score_l      (score_l),
        .score_r      (score_r),
        .goal         (goal),
        .game_over    (game_over)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic check_pos(input int ex, input int ey);
        check_eq($sformatf("t%0d xpos", tick_n), int'(xpos), ex);
        check_eq($sformatf("t%0d ypos", tick_n), int'(ypos), ey);
    endtask

    // One frame: vblank high for a single edge, then seven quiet cycles.
    task automatic do_tick();
        goal_hi  = 0;
        vblnk_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vblnk_in = 1'b0;
            if (goal) goal_hi++;
        end
        tick_n++;
    endtask

    task automatic run_to(input int t);
        while (tick_n < t) do_tick();
    endtask

    task automatic set_l(input int x, input int y);
        mallet_l_xpos = 12'(x);
        mallet_l_ypos = 12'(y);
    endtask

    task automatic set_r(input int x, input int y);
        mallet_r_xpos = 12'(x);
        mallet_r_ypos = 12'(y);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " xpos"},      int'(xpos), 512);
        check_eq({tag, " ypos"},      int'(ypos), 384);
        check_eq({tag, " score_l"},   int'(score_l), 0);
        check_eq({tag, " score_r"},   int'(score_r), 0);
        check_eq({tag, " goal"},      int'(goal), 0);
        check_eq({tag, " game_over"}, int'(game_over), 0);
    endtask

    initial begin
        rst      = 1'b1;
        vblnk_in = 1'b0;
        set_l(4000, 4000);
        set_r(560, 370);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Serve hold, then launch toward +x.
        for (int t = 1; t <= 61; t++) begin
            do_tick();
            check_pos(512, 384);
        end
        do_tick();                 check_pos(515, 384);
        run_to(64);                check_pos(521, 384);
        // Right mallet hit with dy=+14: vx=-8, vy=+3.
        do_tick();                 check_pos(513, 387);
        set_r(4000, 4000);
        do_tick();                 check_pos(505, 390);
        // Left wall outside the goal mouth: clamp and reflect.
        run_to(127);               check_pos(17, 573);
        do_tick();                 check_pos(16, 576);
        check_eq("t128 score_l", int'(score_l), 0);
        check_eq("t128 score_r", int'(score_r), 0);
        do_tick();                 check_pos(24, 579);
        // Left mallet below the puck: vx=+8, vy=clamp(-32>>>2)=-8.
        run_to(139);               check_pos(104, 609);
        set_l(112, 644);
        do_tick();                 check_pos(112, 601);
        set_l(4000, 4000);
        do_tick();                 check_pos(120, 593);
        // Top wall.
        run_to(213);               check_pos(696, 17);
        do_tick();                 check_pos(704, 16);
        do_tick();                 check_pos(712, 24);
        // Right-side goal at y=312.
        run_to(251);               check_pos(1000, 312);
        check_eq("t251 goal cycles", goal_hi, 0);
        do_tick();
        check_eq("t252 goal cycles", goal_hi, 1);
        check_eq("t252 score_l", int'(score_l), 1);
        check_eq("t252 score_r", int'(score_r), 0);
        check_pos(1000, 312);
        run_to(312);               check_pos(1000, 312);
        do_tick();                 check_pos(512, 384);
        run_to(374);               check_pos(512, 384);
        do_tick();                 check_pos(515, 384);

        // Straight +3 serves score on the right until the game ends.
        for (int n = 2; n <= 7; n++) begin
            run_to(540 + 288 * (n - 2));
            check_eq($sformatf("goal%0d score_l", n), int'(score_l), n);
            check_eq($sformatf("goal%0d cycles", n), goal_hi, 1);
            check_eq($sformatf("goal%0d game_over", n), int'(game_over), (n == 7) ? 1 : 0);
            if (n < 7) check_pos(1007, 384);
            else       check_pos(512, 384);
        end
        run_to(1985);
        check_pos(512, 384);
        check_eq("over score_l", int'(score_l), 7);
        check_eq("over score_r", int'(score_r), 0);
        check_eq("over game_over", int'(game_over), 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst after over");

        // Second game: right mallet sends the puck into the left goal.
        tick_n = 0;
        set_r(560, 384);
        run_to(61);                check_pos(512, 384);
        do_tick();                 check_pos(515, 384);
        do_tick();                 check_pos(518, 384);
        do_tick();                 check_pos(510, 384);
        set_r(4000, 4000);
        do_tick();                 check_pos(502, 384);
        run_to(125);               check_pos(22, 384);
        do_tick();
        check_eq("g2 goal cycles", goal_hi, 1);
        check_eq("g2 score_r", int'(score_r), 1);
        check_eq("g2 score_l", int'(score_l), 0);
        check_pos(22, 384);
        run_to(186);               check_pos(22, 384);
        do_tick();                 check_pos(512, 384);
        run_to(248);               check_pos(512, 384);
        do_tick();                 check_pos(509, 384);
        do_tick();                 check_pos(506, 384);

        // Reset lands while a frame is in flight.
        vblnk_in = 1'b1;
        @(negedge clk);
        vblnk_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_pos(512, 384);
        check_eq("midreset score_r", int'(score_r), 0);
        check_eq("midreset goal", int'(goal), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
